// File: rtl/xfer_arbiter_if.sv
// Handshake and crossing-bus signals between launch-side requesters and xfer_arbiter.
// Requester words are packed per index: requester i at [i*AW +: AW] / [i*DW +: DW].
interface xfer_arbiter_if #(
   parameter int N  = 4,
   parameter int AW = 8,
   parameter int DW = 16
);
   logic            sync;
   logic [N-1:0]    req;
   logic [N-1:0]    lock;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    gnt;
   logic            bus_valid;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_data;
   logic [3:0]      bus_tag;
   logic            busy;

   modport master (
      output sync, req, lock, req_addr, req_data,
      input  gnt, bus_valid, bus_addr, bus_data, bus_tag, busy
   );

   modport slave (
      input  sync, req, lock, req_addr, req_data,
      output gnt, bus_valid, bus_addr, bus_data, bus_tag, busy
   );
endinterface

// File: rtl/xfer_arbiter.sv
// Round-robin arbiter with locked bursts for the token-based crossing bus; one grant per sync slot.
// Latency: sync at t -> gnt/bus_*/busy registered at t+1; no backpressure, requesters hold req until gnt.
module xfer_arbiter #(
   parameter int N  = 4,
   parameter int AW = 8,
   parameter int DW = 16
) (
   input logic         clk,
   input logic         reset,
   xfer_arbiter_if.slave xf
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {OPEN, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic          valid_q, valid_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [3:0]    tag_q, tag_d;
   logic          busy_q, busy_d;

   logic          hit;
   logic [PW-1:0] sel;
   int            idx;

   // First requester at or after ptr, wrapping modulo N.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      idx = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!hit && xf.req[idx]) begin
            hit = 1'b1;
            sel = PW'(idx);
         end
      end
   end

   logic          grant;
   logic [PW-1:0] gidx;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_d   = '0;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      tag_d   = tag_q;
      grant   = 1'b0;
      gidx    = '0;

      if (xf.sync) begin
         case (state_q)
            OPEN: begin
               if (hit) begin
                  grant = 1'b1;
                  gidx  = sel;
                  ptr_d = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
                  if (xf.lock[sel]) begin
                     state_d = LOCKED;
                     owner_d = sel;
                  end
               end
            end
            LOCKED: begin
               // Owner keeps the slot; pointer is left where the burst started.
               if (xf.req[owner_q]) begin
                  grant = 1'b1;
                  gidx  = owner_q;
                  if (!xf.lock[owner_q]) state_d = OPEN;
               end else begin
                  state_d = OPEN;
               end
            end
            default: state_d = OPEN;
         endcase

         valid_d = grant;
         if (grant) begin
            addr_d      = xf.req_addr[gidx*AW +: AW];
            data_d      = xf.req_data[gidx*DW +: DW];
            tag_d       = tag_q + 4'd1;
            gnt_d[gidx] = 1'b1;
         end
      end

      busy_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= OPEN;
         ptr_q   <= '0;
         owner_q <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         tag_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
         busy_q  <= busy_d;
      end
   end

   assign xf.gnt       = gnt_q;
   assign xf.bus_valid = valid_q;
   assign xf.bus_addr  = addr_q;
   assign xf.bus_data  = data_q;
   assign xf.bus_tag   = tag_q;
   assign xf.busy      = busy_q;
endmodule

// File: tb/tb_xfer_arbiter.sv
// Scoreboard bench for xfer_arbiter: each slot pushes its expected outcome, then pops it against the DUT.
module tb_xfer_arbiter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   xfer_arbiter_if #(.N(4), .AW(8), .DW(16)) xf();
   xfer_arbiter #(.N(4), .AW(8), .DW(16)) dut (.clk(clk), .reset(reset), .xf(xf));

   typedef struct packed {
      logic [3:0]  gnt;
      logic        valid;
      logic [7:0]  addr;
      logic [15:0] data;
      logic [3:0]  tag;
      logic        busy;
   } obs_t;

   obs_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] addr_of(int i, int w);
      return 8'((i + 1) * 16 + w);
   endfunction

   function automatic logic [15:0] data_of(int i, int w);
      return 16'(16'hA000 + i * 256 + w);
   endfunction

   function automatic obs_t ex(int g, logic v, logic [7:0] a, logic [15:0] d, int t, logic b);
      obs_t o;
      o.gnt   = (g < 0) ? 4'b0000 : 4'(1 << g);
      o.valid = v;
      o.addr  = a;
      o.data  = d;
      o.tag   = 4'(t);
      o.busy  = b;
      return o;
   endfunction

   function automatic obs_t sample();
      return {xf.gnt, xf.bus_valid, xf.bus_addr, xf.bus_data, xf.bus_tag, xf.busy};
   endfunction

   task automatic set_word(int i, int w);
      xf.req_addr[i*8 +: 8]   = addr_of(i, w);
      xf.req_data[i*16 +: 16] = data_of(i, w);
   endtask

   // One token slot: sync for a cycle, observe at t+1, then idle out the round trip.
   task automatic slot(output obs_t g);
      xf.sync = 1'b1;
      @(posedge clk); #1;
      xf.sync = 1'b0;
      g = sample();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t g, e;
      reset = 1'b1;
      xf.sync = 1'b0; xf.req = '0; xf.lock = '0; xf.req_addr = '0; xf.req_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      sb.push_back(ex(-1, 0, 0, 0, 0, 0));
      g = sample(); e = sb.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", g, e); end
   endtask

   task automatic test_idle();
      obs_t g, e;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(ex(-1, 0, 0, 0, 0, 0));
         slot(g); e = sb.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL idle_slot%0d: got %h expected %h", k, g, e); end
      end
   endtask

   task automatic test_round_robin();
      obs_t g, e;
      for (int i = 0; i < 4; i++) set_word(i, 0);
      xf.req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         sb.push_back(ex(k % 4, 1, addr_of(k % 4, 0), data_of(k % 4, 0), k + 1, 0));
         slot(g); e = sb.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL rr_slot%0d: got %h expected %h", k, g, e); end
      end
      // Between slots gnt is low and the bus holds the last word.
      sb.push_back(ex(-1, 1, addr_of(3, 0), data_of(3, 0), 8, 0));
      g = sample(); e = sb.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rr_hold: got %h expected %h", g, e); end
      xf.req = 4'b0000;
   endtask

   task automatic test_pointer();
      obs_t g, e;
      xf.req = 4'b0100;
      sb.push_back(ex(2, 1, addr_of(2, 0), data_of(2, 0), 9, 0));
      slot(g); e = sb.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL ptr_first: got %h expected %h", g, e); end
      xf.req = 4'b0101;
      sb.push_back(ex(0, 1, addr_of(0, 0), data_of(0, 0), 10, 0));
      sb.push_back(ex(2, 1, addr_of(2, 0), data_of(2, 0), 11, 0));
      for (int k = 0; k < 2; k++) begin
         slot(g); e = sb.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL ptr_wrap%0d: got %h expected %h", k, g, e); end
      end
      xf.req = 4'b0000;
   endtask

   task automatic test_burst();
      obs_t g, e;
      xf.req = 4'b0001;
      sb.push_back(ex(0, 1, addr_of(0, 0), data_of(0, 0), 12, 0));
      slot(g); e = sb.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL burst_setup: got %h expected %h", g, e); end
      xf.req = 4'b1010; xf.lock = 4'b0010;
      for (int w = 0; w < 3; w++) begin
         set_word(1, w);
         if (w == 2) xf.lock = 4'b0000;
         sb.push_back(ex(1, 1, addr_of(1, w), data_of(1, w), 13 + w, (w < 2)));
         slot(g); e = sb.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL burst_word%0d: got %h expected %h", w, g, e); end
      end
      xf.req = 4'b1000;
      sb.push_back(ex(3, 1, addr_of(3, 0), data_of(3, 0), 0, 0));
      slot(g); e = sb.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL burst_after_tagwrap: got %h expected %h", g, e); end
      xf.req = 4'b0000;
   endtask

   task automatic test_lock_drop();
      obs_t g, e;
      set_word(0, 5);
      xf.req = 4'b0001; xf.lock = 4'b0001;
      sb.push_back(ex(0, 1, addr_of(0, 5), data_of(0, 5), 1, 1));
      slot(g); e = sb.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL drop_lockgrant: got %h expected %h", g, e); end
      xf.req = 4'b0100; xf.lock = 4'b0000;
      sb.push_back(ex(-1, 0, addr_of(0, 5), data_of(0, 5), 1, 0));
      sb.push_back(ex(2, 1, addr_of(2, 0), data_of(2, 0), 2, 0));
      for (int k = 0; k < 2; k++) begin
         slot(g); e = sb.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL drop_slot%0d: got %h expected %h", k, g, e); end
      end
      xf.req = 4'b0000;
   endtask

   task automatic test_reset_locked();
      obs_t g, e;
      xf.req = 4'b0010; xf.lock = 4'b0010;
      sb.push_back(ex(1, 1, addr_of(1, 2), data_of(1, 2), 3, 1));
      slot(g); e = sb.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rstlk_enter: got %h expected %h", g, e); end
      reset = 1'b1; xf.sync = 1'b1;
      @(posedge clk); #1;
      xf.sync = 1'b0; reset = 1'b0;
      sb.push_back(ex(-1, 0, 0, 0, 0, 0));
      g = sample(); e = sb.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rstlk_reset: got %h expected %h", g, e); end
      repeat (3) @(posedge clk);
      #1;
      xf.req = 4'b1111; xf.lock = 4'b0000;
      sb.push_back(ex(0, 1, addr_of(0, 5), data_of(0, 5), 1, 0));
      slot(g); e = sb.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rstlk_rearb: got %h expected %h", g, e); end
      xf.req = 4'b0000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idle();
      test_round_robin();
      test_pointer();
      test_burst();
      test_lock_drop();
      test_reset_locked();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/xfer_arbiter.md
# xfer_arbiter

Shares the token-based clock-domain-crossing parameter bus between several requesters in the launching clock domain. Each token pulse from the domain-crossing handshake opens one transfer slot. In that slot the block loads one requester's address/data word onto the crossing bus and acknowledges that requester. Grants go in round-robin order, with optional locked bursts. The block sits between the CPU/register-file side logic and the handshake's launch side.

## Interface
- `N`, 4: number of requesters (2..8).
- `AW`, 8: address width.
- `DW`, 16: data width.
- `clk` in 1: launch-domain clock. Same clock as the handshake's launch side.
- `reset` in 1: synchronous, active-high.
- `sync` in 1: token pulse from the handshake launch side. High for one `clk` cycle per slot.
- `req` in N: per-requester request, level. Held until the matching `gnt` bit pulses.
- `lock` in N: per-requester burst lock. Sampled together with `req`.
- `req_addr` in N*AW: requester i occupies bits [i*AW +: AW].
- `req_data` in N*DW: requester i occupies bits [i*DW +: DW].
- `gnt` out N: one-hot, one-cycle acknowledge.
- `bus_valid` out 1: current slot carries a write.
- `bus_addr` out AW: crossing-bus address.
- `bus_data` out DW: crossing-bus data.
- `bus_tag` out 4: transfer sequence number. Increments per valid transfer.
- `busy` out 1: a lock is held (state LOCKED).

## Operation
- All outputs are registered. Reset values:
  - `gnt`=0, `bus_valid`=0, `bus_addr`=0, `bus_data`=0, `bus_tag`=0, `busy`=0.
  - Internal round-robin pointer `ptr`=0; state=OPEN.
- Bus registers change only in the cycle after `sync`=1. Otherwise they hold, so they are stable for the whole token round trip.
- State OPEN, on `sync`=1:
  - Select the first i with `req[i]`=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - Load `bus_addr`/`bus_data` from requester i, set `bus_valid`=1, `bus_tag`+1 (wraps 15→0), pulse `gnt[i]`.
  - Set `ptr` to (i+1) mod N.
  - If `lock[i]`=1: enter LOCKED with owner=i, `busy`=1.
  - If no `req` is set: `bus_valid`=0, `bus_addr`/`bus_data`/`bus_tag` hold, no `gnt`, `ptr` unchanged.
- State LOCKED (owner o), on `sync`=1:
  - If `req[o]`=1: grant o regardless of `ptr` (same load/tag/gnt as above), `ptr` unchanged. If `lock[o]`=0 on that grant, return to OPEN and drop `busy`. That grant is the final burst word.
  - If `req[o]`=0: idle slot (`bus_valid`=0), return to OPEN, drop `busy`. Other requesters wait for the next slot.
- Requester protocol:
  - `req`/`lock`/`addr`/`data` stay stable from assertion until `gnt`.
  - In the cycle after `gnt`, the requester either drops `req` or presents the next word. A still-asserted `req` at a later `sync` is a new request.
- `sync` with `reset`=1: reset wins; no grant, slot lost.
- `reset` mid-burst: LOCKED aborts to OPEN. Requester sees no `gnt` and must re-request.

## Timing
- `sync` at cycle t gives `gnt`, `bus_*`, `bus_tag` and `busy` updated at t+1. `gnt` is high only at t+1.
- Bus contents stay valid from t+1 until the cycle after the next `sync`.
- Selection uses `req`/`lock`/`addr`/`data` as sampled at cycle t.
- The token round trip is ≥ 4 `clk` cycles, so back-to-back `sync` never occurs. If it does anyway, each pulse is treated as an independent slot.
- Worst-case wait with all N requesting and no locks: N slots. With locks, the wait is unbounded by design; the lock owner is responsible for limiting burst length.

## Test plan
- Reset, then `req`=0 and three `sync` pulses -> `bus_valid`=0 every slot; `gnt`=0; `bus_tag`=0; `ptr` stays 0.
- `req`=4'b1111, no locks, 8 `sync` pulses -> `gnt` sequence 0,1,2,3,0,1,2,3. `bus_addr`/`bus_data` match each granted requester. `bus_tag` goes 1..8.
- `req`=4'b0100 only -> first slot grants 2 and sets `ptr`=3. Then add `req[0]` -> next slot grants 0, following slot grants 2 again.
- Requester 1 bursts 3 words (`lock`=1,1,0) while `req[3]`=1 -> grants 1,1,1,3. `busy`=1 after the first and second grants, 0 after the third.
- Lock owner drops `req` while LOCKED -> that slot has `bus_valid`=0 and `busy` falls. The next slot grants the round-robin winner.
- `reset` asserted during LOCKED, coincident with `sync` -> no `gnt`, all outputs at reset values, `ptr`=0, state OPEN. The next `sync` arbitrates from 0.
